aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key-schedule engine that sits directly upstream of the round stages. It feeds the 128-bit `round_keyin` of every `round_transform*` instance. Software/top-level loads one cipher key, and the block computes round keys 1..10 at one key per clock into an internal key file. Round stages then read their key by index through a combinational read port.

## Interface
Parameters:
- `NR`, 10: number of rounds; key file holds `NR+1` entries. Only 10 (AES-128) is supported.

Ports:
- `clk`: input, 1. Single clock; all state is updated on its rising edge.
- `rst`: input, 1. Reset, synchronous and active-high.
- `key_load`: input, 1. Single-cycle request to start expansion of `key_in`.
- `key_in`: input, 128. Cipher key; `[127:120]` is byte 0; `w0=[127:96]`.
- `busy`: output, 1. High while expansion is in progress.
- `keys_valid`: output, 1. High when all `NR+1` round keys are stored and stable.
- `expand_done`: output, 1. One-cycle pulse on the cycle `keys_valid` first rises.
- `rd_idx`: input, 4. Round-key index 0..10.
- `rd_key`: output, 128. Round key `rd_idx`. Combinational from the key file.

## Operation
- FSM states: IDLE, EXPAND, READY.
  - Reset → IDLE.
  - IDLE/READY + `key_load` → EXPAND.
  - EXPAND with `cnt==NR` written → READY.
  - EXPAND + `key_load` → restart EXPAND with the new key; the old expansion is abandoned.
- On `key_load`:
  - `rk[0] <= key_in`, `rcon <= 8'h01`, `cnt <= 1`.
  - `keys_valid <= 0`, `busy <= 1`.
- Each EXPAND cycle, with `p = rk[cnt-1] = {w0,w1,w2,w3}`:
  - `t = SubWord(RotWord(w3)) ^ {rcon,24'h0}`.
  - `RotWord({a,b,c,d}) = {b,c,d,a}`.
  - `n0=w0^t`, `n1=w1^n0`, `n2=w2^n1`, `n3=w3^n2`.
  - `rk[cnt] <= {n0,n1,n2,n3}`, `cnt <= cnt+1`, `rcon <= xtime(rcon)`.
- `xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0)`.
- Resulting rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Only one previous key is live, so one path of 4 S-boxes is shared by all iterations.
- Read port:
  - `rd_key = rk[rd_idx]` when `rd_idx <= NR`.
  - `rd_key = 128'h0` when `rd_idx > NR`.
  - Entries with index ≥ `cnt` during EXPAND hold stale data. Consumers must gate on `keys_valid`.
- `rst` has priority over `key_load`. Reset mid-expansion returns the block to IDLE and clears all key-file entries, `cnt`, `rcon` and outputs.

## Timing
- Reset values:
  - `busy=0`, `keys_valid=0`, `expand_done=0`.
  - Key file all zero, so `rd_key=0` for every index.
- Load edge E0 registers `rk[0]`. Edges E1..E10 register `rk[1]`..`rk[10]`.
- After E10:
  - `keys_valid=1`, `busy=0`, `expand_done=1` for exactly one cycle.
  - Latency is `NR` cycles from the load edge.
- `rk[0]` is readable one cycle after the load edge; the round-0 AddRoundKey may start then.
- `keys_valid` stays high in READY until the next `key_load` or `rst`. It drops on the edge that accepts `key_load`.
- `key_load` held high for multiple cycles restarts expansion every cycle. Callers must pulse it.
- `rd_idx` to `rd_key` is purely combinational, with no added latency. A round stage may register the key itself.

## Structure
- Shared package `aes_pkg`:
  - `AES_NR=10`.
  - `typedef logic [127:0] aes_block_t`, `typedef logic [31:0] aes_word_t`.
  - `function xtime`, `function rot_word`.
  - The S-box table, so `SubBytes32` and this block share one definition.
- One sub-module: `aes_sub_word`, a combinational 4× S-box on a 32-bit word, instantiated once.
- Remaining logic (FSM, counter, rcon register, 11×128 key file, read mux) stays in `aes_key_expand`.

## Test plan
- FIPS-197 key:
  - Stimulus: `key_load` with `key_in=2b7e151628aed2a6abf7158809cf4f3c`.
  - Expect `rd_key[1]=a0fafe1788542cb123a339392a6c7605` and `rd_key[10]=d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - Expect `expand_done` exactly 10 cycles after the load edge.
- All-zero key:
  - Expect `rk[1]=62636363626363636263636362636363`.
  - Expect `rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e`.
- Restart:
  - Stimulus: zero key loaded, then the FIPS key loaded after 5 EXPAND cycles.
  - Expect one `expand_done`, 10 cycles after the second load, with FIPS keys.
- Reset mid-expansion:
  - Stimulus: `rst` asserted on EXPAND cycle 4.
  - Expect next cycle `busy=0`, `keys_valid=0`, `rd_key=0` for indices 0..10, and no `expand_done`.
- Read-port bounds: in READY, `rd_idx=11..15` → `rd_key=0`; `rd_idx=0` → original key.
- Reload from READY: a new `key_load` drops `keys_valid` on the accepting edge. It must not rise again for 10 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, block/word types, GF(2^8) helpers and the S-box table.
// The key schedule and any SubBytes logic both take the S-box from here.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four S-box lookups applied bytewise to a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t sub
);

  assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry key file,
// with a combinational indexed read port for the round stages.
//   state  | meaning
//   IDLE   | no key loaded since reset
//   EXPAND | computing rk[cnt] from rk[cnt-1]
//   READY  | all round keys stored, keys_valid high
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  aes_block_t   key_in,
  output logic         busy,
  output logic         keys_valid,
  output logic         expand_done,
  input  logic [3:0]   rd_idx,
  output aes_block_t   rd_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] rcon;
  aes_block_t rk [NR+1];

  logic [3:0] prev_idx;
  aes_block_t prev;
  aes_word_t  rot;
  aes_word_t  sub;
  aes_word_t  t;
  aes_word_t  n0, n1, n2, n3;
  aes_block_t next_key;

  // Only the previous key is needed, so a single SubWord path serves every round.
  always_comb begin
    prev_idx = (cnt != 4'd0) ? (cnt - 4'd1) : 4'd0;
    prev     = rk[prev_idx];
    rot      = rot_word(prev[31:0]);
    t        = sub ^ {rcon, 24'h0};
    n0       = prev[127:96] ^ t;
    n1       = prev[95:64]  ^ n0;
    n2       = prev[63:32]  ^ n1;
    n3       = prev[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  aes_sub_word u_sub_word (
    .word (rot),
    .sub  (sub)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rcon        <= 8'h00;
      busy        <= 1'b0;
      keys_valid  <= 1'b0;
      expand_done <= 1'b0;
      for (int i = 0; i < NR + 1; i++) rk[i] <= '0;
    end else begin
      expand_done <= 1'b0;
      if (key_load) begin
        // A load in any state restarts from the new key; a partial expansion is dropped.
        state      <= EXPAND;
        rk[0]      <= key_in;
        rcon       <= 8'h01;
        cnt        <= 4'd1;
        busy       <= 1'b1;
        keys_valid <= 1'b0;
      end else begin
        case (state)
          EXPAND: begin
            rk[cnt] <= next_key;
            cnt     <= cnt + 4'd1;
            rcon    <= xtime(rcon);
            if (cnt == NR_IDX) begin
              state       <= READY;
              busy        <= 1'b0;
              keys_valid  <= 1'b1;
              expand_done <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= NR_IDX) rd_key = rk[rd_idx];
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;
  import aes_pkg::*;

  localparam aes_block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_block_t FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam aes_block_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_block_t ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam aes_block_t ZERO_RK2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam aes_block_t ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_load;
  aes_block_t key_in;
  logic       busy;
  logic       keys_valid;
  logic       expand_done;
  logic [3:0] rd_idx;
  aes_block_t rd_key;

  int n_chk  = 0;
  int n_pass = 0;

  aes_key_expand dut (
    .clk         (clk),
    .rst         (rst),
    .key_load    (key_load),
    .key_in      (key_in),
    .busy        (busy),
    .keys_valid  (keys_valid),
    .expand_done (expand_done),
    .rd_idx      (rd_idx),
    .rd_key      (rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input aes_block_t k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  // Runs n cycles, reporting the first cycle expand_done was seen (0 if never) and the pulse count.
  task automatic watch(input int n, output int first, output int pulses);
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (expand_done) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic read_key(input logic [3:0] idx, output aes_block_t k);
    rd_idx = idx;
    #1;
    k = rd_key;
  endtask

  initial begin
    int         first, pulses;
    aes_block_t k;
    logic       early_valid;

    rst = 1'b1; key_load = 1'b0; key_in = '0; rd_idx = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_valid", {127'b0, keys_valid}, 128'd0);
    chk("reset_done", {127'b0, expand_done}, 128'd0);
    for (int i = 0; i <= 10; i++) begin
      read_key(4'(i), k);
      chk($sformatf("reset_rk%0d", i), k, 128'd0);
    end

    // FIPS-197 key
    load_key(FIPS_KEY);
    chk("fips_busy_after_load", {127'b0, busy}, 128'd1);
    read_key(4'd0, k);
    chk("fips_rk0_early", k, FIPS_KEY);
    watch(15, first, pulses);
    chk("fips_done_latency", 128'(first), 128'd10);
    chk("fips_done_pulses", 128'(pulses), 128'd1);
    chk("fips_valid", {127'b0, keys_valid}, 128'd1);
    chk("fips_busy_ready", {127'b0, busy}, 128'd0);
    read_key(4'd1, k);  chk("fips_rk1", k, FIPS_RK1);
    read_key(4'd2, k);  chk("fips_rk2", k, FIPS_RK2);
    read_key(4'd10, k); chk("fips_rk10", k, FIPS_RK10);

    // Read-port bounds
    for (int i = 11; i <= 15; i++) begin
      read_key(4'(i), k);
      chk($sformatf("bound_idx%0d", i), k, 128'd0);
    end
    read_key(4'd0, k); chk("bound_idx0", k, FIPS_KEY);

    // Reload from READY with the all-zero key
    load_key(128'd0);
    chk("reload_valid_drop", {127'b0, keys_valid}, 128'd0);
    early_valid = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (keys_valid) early_valid = 1'b1;
      if (expand_done) pulses++;
    end
    chk("reload_valid_early", {127'b0, early_valid}, 128'd0);
    chk("reload_done_early", 128'(pulses), 128'd0);
    tick();
    chk("reload_valid_c10", {127'b0, keys_valid}, 128'd1);
    chk("reload_done_c10", {127'b0, expand_done}, 128'd1);
    read_key(4'd1, k);  chk("zero_rk1", k, ZERO_RK1);
    read_key(4'd2, k);  chk("zero_rk2", k, ZERO_RK2);
    read_key(4'd10, k); chk("zero_rk10", k, ZERO_RK10);

    // Restart: zero key abandoned after 5 EXPAND cycles, FIPS key takes over
    load_key(128'd0);
    watch(5, first, pulses);
    chk("restart_no_early_done", 128'(pulses), 128'd0);
    load_key(FIPS_KEY);
    watch(15, first, pulses);
    chk("restart_done_latency", 128'(first), 128'd10);
    chk("restart_done_pulses", 128'(pulses), 128'd1);
    read_key(4'd1, k);  chk("restart_rk1", k, FIPS_RK1);
    read_key(4'd10, k); chk("restart_rk10", k, FIPS_RK10);

    // Reset during EXPAND cycle 4
    load_key(ZERO_RK1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_valid", {127'b0, keys_valid}, 128'd0);
    for (int i = 0; i <= 10; i++) begin
      read_key(4'(i), k);
      chk($sformatf("rst_rk%0d", i), k, 128'd0);
    end
    watch(12, first, pulses);
    chk("rst_no_done", 128'(pulses), 128'd0);
    chk("rst_stays_idle", {126'b0, busy, keys_valid}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
